// File: rtl/score_accum.sv
// Ten-class MAC score accumulator: registered products, then accumulate, feeding argmax.
// Optional build macro SCORE_SAT_EN: saturate accumulators instead of wrapping.
module score_accum #(
  parameter int N_FEATURES = 784,
  parameter int ACC_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [79:0]      in_weights,
  output logic             in_ready,
  output logic [ACC_W-1:0] final0,
  output logic [ACC_W-1:0] final1,
  output logic [ACC_W-1:0] final2,
  output logic [ACC_W-1:0] final3,
  output logic [ACC_W-1:0] final4,
  output logic [ACC_W-1:0] final5,
  output logic [ACC_W-1:0] final6,
  output logic [ACC_W-1:0] final7,
  output logic [ACC_W-1:0] final8,
  output logic [ACC_W-1:0] final9,
  output logic             out_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_FEATURES + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      prod [10];
  logic             pvalid;
  logic [ACC_W-1:0] acc [10];
  logic [ACC_W:0]   sum_w [10];
  logic [ACC_W-1:0] acc_next [10];
  logic             accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    for (int unsigned k = 0; k < 10; k++) begin
      sum_w[k] = {1'b0, acc[k]} + {{(ACC_W-15){1'b0}}, prod[k]};
`ifdef SCORE_SAT_EN
      // Carry out means overflow; once at all-ones any further add keeps it there.
      acc_next[k] = sum_w[k][ACC_W] ? '1 : sum_w[k][ACC_W-1:0];
`else
      acc_next[k] = sum_w[k][ACC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pvalid    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned k = 0; k < 10; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      pvalid    <= accept;
      out_valid <= 1'b0;
      for (int unsigned k = 0; k < 10; k++) begin
        if (accept)
          prod[k] <= 16'(in_data) * 16'(in_weights[8*k +: 8]);
        if (pvalid)
          acc[k] <= acc_next[k];
      end
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < 10; k++)
              acc[k] <= '0;
            cnt      <= '0;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(N_FEATURES - 1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign final0 = acc[0];
  assign final1 = acc[1];
  assign final2 = acc[2];
  assign final3 = acc[3];
  assign final4 = acc[4];
  assign final5 = acc[5];
  assign final6 = acc[6];
  assign final7 = acc[7];
  assign final8 = acc[8];
  assign final9 = acc[9];

endmodule

// File: tb/tb_score_accum.sv
// Randomized self-checking bench for score_accum against a dot-product reference model.
module tb_score_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Instance A: N_FEATURES=4, ACC_W=26
  logic a_start = 0, a_valid = 0, a_ready, a_ov, a_busy;
  logic [7:0]  a_data = 0;
  logic [79:0] a_w = 0;
  logic [25:0] a_f [10];

  score_accum #(.N_FEATURES(4), .ACC_W(26)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_data(a_data),
    .in_weights(a_w), .in_ready(a_ready),
    .final0(a_f[0]), .final1(a_f[1]), .final2(a_f[2]), .final3(a_f[3]), .final4(a_f[4]),
    .final5(a_f[5]), .final6(a_f[6]), .final7(a_f[7]), .final8(a_f[8]), .final9(a_f[9]),
    .out_valid(a_ov), .busy(a_busy));

  // Instance B: N_FEATURES=2, ACC_W=16
  logic b_start = 0, b_valid = 0, b_ready, b_ov, b_busy;
  logic [7:0]  b_data = 0;
  logic [79:0] b_w = 0;
  logic [15:0] b_f [10];

  score_accum #(.N_FEATURES(2), .ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_weights(b_w), .in_ready(b_ready),
    .final0(b_f[0]), .final1(b_f[1]), .final2(b_f[2]), .final3(b_f[3]), .final4(b_f[4]),
    .final5(b_f[5]), .final6(b_f[6]), .final7(b_f[7]), .final8(b_f[8]), .final9(b_f[9]),
    .out_valid(b_ov), .busy(b_busy));

  // Instance C: default parameters
  logic c_start = 0, c_valid = 0, c_ready, c_ov, c_busy;
  logic [7:0]  c_data = 0;
  logic [79:0] c_w = 0;
  logic [25:0] c_f [10];

  score_accum dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_valid), .in_data(c_data),
    .in_weights(c_w), .in_ready(c_ready),
    .final0(c_f[0]), .final1(c_f[1]), .final2(c_f[2]), .final3(c_f[3]), .final4(c_f[4]),
    .final5(c_f[5]), .final6(c_f[6]), .final7(c_f[7]), .final8(c_f[8]), .final9(c_f[9]),
    .out_valid(c_ov), .busy(c_busy));

  // Reference model: exact dot product, then the build's overflow policy.
  function automatic longint unsigned fold(input longint unsigned sum, input int w);
    longint unsigned lim;
    lim = (64'd1 << w);
`ifdef SCORE_SAT_EN
    return (sum >= lim) ? lim - 1 : sum;
`else
    return sum % lim;
`endif
  endfunction

  logic [7:0]  bd [4];
  logic [79:0] bw [4];
  longint unsigned expv [10];

  task automatic model_a;
    for (int k = 0; k < 10; k++) begin
      longint unsigned s;
      logic [79:0] wv;
      s = 0;
      for (int i = 0; i < 4; i++) begin
        wv = bw[i];
        s += longint'(bd[i]) * longint'(wv[8*k +: 8]);
      end
      expv[k] = fold(s, 26);
    end
  endtask

  task automatic check_finals_a(input string tag);
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (longint'(a_f[k]) !== expv[k]) begin
        mismatched++;
        $display("FAIL %s final%0d got=%0d exp=%0d", tag, k, a_f[k], expv[k]);
      end
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // mode: 0 back-to-back, 1 alternate stall, 2 random stall
  task automatic run_a(input int mode, input bit start_noise, input string tag);
    int i, cyc;
    bit tog;
    model_a();
    @(negedge clk); a_start = 1;
    @(negedge clk); a_start = start_noise;
    chk1({tag, "_busy"}, a_busy, 1'b1);
    chk1({tag, "_ready"}, a_ready, 1'b1);
    i = 0; cyc = 0; tog = 0;
    while (i < 4 && cyc < 200) begin
      if ((mode == 1 && tog) || (mode == 2 && $urandom_range(99) < 40) || !a_ready) begin
        a_valid = 0;
        a_data = 8'($urandom);
      end else begin
        a_valid = 1; a_data = bd[i]; a_w = bw[i]; i++;
      end
      tog = ~tog;
      @(negedge clk); cyc++;
    end
    compared++;
    if (i != 4) begin
      mismatched++;
      $display("FAIL %s_timeout beats=%0d exp=4", tag, i);
    end
    // Junk beats after the last accepted one must be ignored.
    a_valid = 1; a_data = 8'hFF; a_w = '1;
    chk1({tag, "_ov_drain"}, a_ov, 1'b0);
    chk1({tag, "_ready_after"}, a_ready, 1'b0);
    @(negedge clk);
    chk1({tag, "_ov_done"}, a_ov, 1'b1);
    check_finals_a({tag, "_done"});
    @(negedge clk);
    a_start = 0; a_valid = 0;
    chk1({tag, "_ov_after"}, a_ov, 1'b0);
    chk1({tag, "_idle"}, a_busy, 1'b0);
  endtask

  task automatic fill_const(input logic [7:0] d, input logic [7:0] w);
    for (int i = 0; i < 4; i++) begin
      bd[i] = d;
      bw[i] = {10{w}};
    end
  endtask

  task automatic test_reset;
    #1;
    chk1("rst_ready", a_ready, 1'b0);
    chk1("rst_ov", a_ov, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    compared++;
    if (a_f[0] !== '0 || a_f[9] !== '0) begin
      mismatched++;
      $display("FAIL rst_finals got=%0d,%0d exp=0", a_f[0], a_f[9]);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    fill_const(8'd1, 8'd1);
    run_a(0, 0, "s1");
  endtask

  task automatic test_alt_stall;
    for (int i = 0; i < 4; i++) begin
      bd[i] = 8'd255;
      for (int k = 0; k < 10; k++) bw[i][8*k +: 8] = 8'(k);
    end
    run_a(1, 0, "s2");
  endtask

  task automatic test_mid_reset;
    @(negedge clk); a_start = 1;
    @(negedge clk); a_start = 0;
    a_valid = 1; a_data = 8'd7; a_w = {10{8'd9}};
    @(negedge clk);
    @(negedge clk);
    a_valid = 0;
    #2 rst_n = 0;
    #1;
    chk1("s3_ready", a_ready, 1'b0);
    chk1("s3_busy", a_busy, 1'b0);
    chk1("s3_ov", a_ov, 1'b0);
    compared++;
    if (a_f[3] !== '0) begin
      mismatched++;
      $display("FAIL s3_async_clear got=%0d exp=0", a_f[3]);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk1("s3_stay_idle", a_busy, 1'b0);
    fill_const(8'd2, 8'd3);
    run_a(0, 0, "s3");
  endtask

  task automatic test_start_ignored;
    fill_const(8'd11, 8'd13);
    run_a(2, 1, "s4");
    for (int c = 0; c < 10; c++) @(negedge clk);
    check_finals_a("s4_hold");
    chk1("s4_hold_idle", a_busy, 1'b0);
  endtask

  task automatic test_random;
    for (int img = 0; img < 6; img++) begin
      for (int i = 0; i < 4; i++) begin
        bd[i] = 8'($urandom);
        bw[i] = {$urandom, $urandom, $urandom};
      end
      run_a(2, 0, "rnd");
    end
  endtask

  task automatic test_sat;
    int n, cyc;
    bit seen;
    longint unsigned e;
    e = fold(2 * 65025, 16);
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    b_valid = 1; b_data = 8'd255; b_w = '1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      if (b_ready) n++;
      @(negedge clk); cyc++;
    end
    b_valid = 0;
    seen = 0; cyc = 0;
    while (!seen && cyc < 10) begin
      if (b_ov) seen = 1; else begin @(negedge clk); cyc++; end
    end
    chk1("s5_ov", seen, 1'b1);
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (longint'(b_f[k]) !== e) begin
        mismatched++;
        $display("FAIL s5_final%0d got=%0d exp=%0d", k, b_f[k], e);
      end
    end
  endtask

  task automatic test_full;
    int n, cyc, pulses;
    longint unsigned e;
    e = fold(784 * 65025, 26);
    @(negedge clk); c_start = 1;
    @(negedge clk); c_start = 0;
    c_valid = 1; c_data = 8'd255; c_w = '1;
    n = 0; cyc = 0; pulses = 0;
    while (n < 784 && cyc < 2000) begin
      if (c_ready) n++;
      if (c_ov) pulses++;
      @(negedge clk); cyc++;
    end
    c_valid = 0;
    for (int c = 0; c < 8; c++) begin
      if (c_ov) pulses++;
      @(negedge clk);
    end
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("FAIL s6_pulses got=%0d exp=1", pulses);
    end
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (longint'(c_f[k]) !== e) begin
        mismatched++;
        $display("FAIL s6_final%0d got=%0d exp=%0d", k, c_f[k], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alt_stall();
    test_mid_reset();
    test_start_ignored();
    test_random();
    test_sat();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/score_accum.md
SCORE_ACCUM -- requirements
Module: score_accum

Interface
REQ-001 SHALL have parameter N_FEATURES, default 784, meaning feature beats accumulated per image.
REQ-002 SHALL have parameter ACC_W, default 26, meaning width of each class score, matching the argmax stage's score width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a new image; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  in_data/in_weights carry a valid feature beat.
REQ-007 SHALL have port in_data  input  8  unsigned feature value.
REQ-008 SHALL have port in_weights  input  80  ten unsigned 8-bit weights; class k at bits [8k+7:8k].
REQ-009 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-010 SHALL have ports final0..final9  output  ACC_W each  class scores feeding the argmax stage.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse: final0..final9 complete.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
REQ-014 IDLE: start=1 SHALL clear all ten accumulators and the beat counter and enter ACCUM on the same edge.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 in_ready SHALL be high only in ACCUM.
REQ-017 Stage 1: on each accepted beat, ten 16-bit products in_data*weight_k SHALL be registered, together with a product-valid flag.
REQ-018 Stage 2: on the edge after a product-valid cycle, each product SHALL be zero-extended and added to accumulator k.
REQ-019 The beat counter SHALL count accepted beats; the edge accepting beat N_FEATURES SHALL move ACCUM -> DRAIN.
REQ-020 DRAIN SHALL last exactly one cycle, during which the last product is added; the state then moves to DONE.
REQ-021 out_valid SHALL be high only during the single DONE cycle, i.e. the second edge after the last accepted beat; DONE -> IDLE unconditionally.
REQ-022 final0..final9 SHALL be driven directly from the accumulators and SHALL hold their values after DONE until the next accepted start.
REQ-023 In ACCUM, in_valid=0 SHALL stall: no count or accumulate change beyond draining an already-registered product.
REQ-024 in_valid outside ACCUM SHALL be ignored, with no product registered.
REQ-025 Once N_FEATURES beats are accepted, no further beat SHALL be accepted for that image.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=0, out_valid=0, busy=0, all accumulators, product registers, product-valid and the counter to 0, regardless of the current state.
REQ-027 On deassertion of reset mid-image, the block SHALL stay in IDLE, and partial scores SHALL NOT be recovered.

Configuration
REQ-028 Macro SCORE_SAT_EN defined: each accumulator SHALL saturate at 2^ACC_W-1 and hold there for the rest of the image.
REQ-029 Macro SCORE_SAT_EN undefined: accumulators SHALL wrap modulo 2^ACC_W.
REQ-030 No other behaviour SHALL differ between the two builds.

Verification (bench uses N_FEATURES=4 unless stated)
REQ-031 Scenario 1: start; 4 back-to-back beats in_data=1, all weights=1 -> out_valid 2 edges after the 4th beat; final0..final9=4.
REQ-032 Scenario 2: start; beats with in_data=255 and weight k=k, 4 beats with in_valid low on alternate cycles -> finalk=4*255*k, out_valid exactly once, in_ready low after the 4th beat.
REQ-033 Scenario 3: rst_n pulsed low after 2 accepted beats -> outputs 0 asynchronously, IDLE; a new start plus 4 beats of value 2, weight 3 -> finals=24.
REQ-034 Scenario 4: start asserted during ACCUM and again during DONE -> ignored; scores unchanged; finals held through 10 idle cycles afterwards.
REQ-035 Scenario 5: ACC_W=16, 2 beats of 255x255 -> with SCORE_SAT_EN finals=65535; without it finals=(2*65025) mod 65536=64514.
REQ-036 Scenario 6: default parameters, 784 beats of 255x255 -> finals=50979600, no overflow, out_valid once.
